bird_io_bridge: RTL and testbench

Memory-mapped I/O bridge sitting directly downstream of the bird CPU's memory port (address / data_out / memwt / data_in). It routes RAM accesses through to the 4K×16 program/data RAM. It claims the top 16 words of the address space for a UART transmitter with a transmit FIFO, status, baud divisor and control registers. It returns combinational read data so the CPU's single-cycle LD/POP2/RET2 timing is preserved.

---
 rtl/bird_io_pkg.sv | 33 +++
 rtl/bird_tx_fifo.sv | 59 +++++
 rtl/bird_io_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_bird_io_bridge.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bird_io_pkg.sv
// rtl/bird_io_pkg.sv - shared constants and types for the bird I/O bridge
// Contents: register offsets, STATUS/CTRL bit positions, TX FSM state enum.

package bird_io_pkg;

  // Register offsets within the 16-word I/O window
  localparam logic [3:0] REG_TXDATA  = 4'd0;
  localparam logic [3:0] REG_STATUS  = 4'd1;
  localparam logic [3:0] REG_BAUDDIV = 4'd2;
  localparam logic [3:0] REG_CTRL    = 4'd3;

  // STATUS bit positions; the FIFO count occupies [10:4]
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 7;

  // CTRL bit positions
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_ODD_PAR = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/bird_tx_fifo.sv
// rtl/bird_tx_fifo.sv - synchronous byte FIFO feeding the UART transmitter
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata (head, combinational),
//        full, empty, count. A push while full is accepted only if a pop lands
//        in the same cycle; a pop while empty is ignored.

module bird_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot the push needs, so full alone does not block it
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bird_io_bridge.sv
// rtl/bird_io_bridge.sv - CPU memory-port bridge: RAM pass-through plus UART TX registers
// Ports: clk, rst_n (async active-low); cpu_address/cpu_wdata/cpu_memwt from the CPU,
//        cpu_rdata back to the CPU (combinational); ram_rdata/ram_we to the RAM;
//        uart_tx serial output (idle high).
// Build option: BIRD_IO_PARITY_EN adds a parity bit after the data bits, with CTRL[2]
//        selecting odd parity.

module bird_io_bridge #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RESET = 16'd433,
  parameter logic [11:0] IO_BASE    = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] cpu_address,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_memwt,
  output logic [15:0] cpu_rdata,
  input  logic [15:0] ram_rdata,
  output logic        ram_we,
  output logic        uart_tx
);

  import bird_io_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  logic       io_sel;
  logic [3:0] reg_off;
  logic       io_wr;

  assign io_sel  = (cpu_address[11:4] == IO_BASE[11:4]);
  assign reg_off = cpu_address[3:0];
  assign io_wr   = cpu_memwt & io_sel;
  assign ram_we  = cpu_memwt & ~io_sel;

  // ---------------------------------------------------------------- FIFO
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  assign fifo_push = io_wr && (reg_off == REG_TXDATA);

  bird_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (cpu_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------- registers
  logic [15:0] baud_div;
  logic        tx_en;
  logic        overflow;
  logic        odd_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_div <= BAUD_RESET;
      tx_en    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      // A dropped push is one that found the FIFO full with no pop freeing a slot
      if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
      if (io_wr && (reg_off == REG_BAUDDIV)) baud_div <= cpu_wdata;
      if (io_wr && (reg_off == REG_CTRL)) begin
        tx_en <= cpu_wdata[CTRL_TX_EN];
        if (cpu_wdata[CTRL_CLR_OVF]) overflow <= 1'b0;
      end
    end
  end

`ifdef BIRD_IO_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odd_par <= 1'b0;
    end else if (io_wr && (reg_off == REG_CTRL)) begin
      odd_par <= cpu_wdata[CTRL_ODD_PAR];
    end
  end
`else
  assign odd_par = 1'b0;
`endif

  // ---------------------------------------------------------------- TX FSM
  tx_state_e   state;
  tx_state_e   state_d;
  logic [15:0] baud_cnt;
  logic [15:0] baud_d;
  logic [2:0]  bit_idx;
  logic [2:0]  idx_d;
  logic [7:0]  shreg;
  logic [7:0]  shreg_d;
  logic        bit_end;

  assign bit_end = (baud_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= idx_d;
      shreg    <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state;
    baud_d   = baud_cnt;
    idx_d    = bit_idx;
    shreg_d  = shreg;
    fifo_pop = 1'b0;

    // Every bit reloads the counter from the live BAUDDIV, so a new divisor
    // applies from the next bit boundary onward.
    if ((state != TX_IDLE) && !bit_end) baud_d = baud_cnt - 16'd1;

    case (state)
      TX_IDLE: begin
        if (tx_en && !fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_head;
          baud_d   = baud_div;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          idx_d   = 3'd0;
          baud_d  = baud_div;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          idx_d  = bit_idx + 3'd1;
          baud_d = baud_div;
          if (bit_idx == 3'd7) begin
`ifdef BIRD_IO_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef BIRD_IO_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          baud_d  = baud_div;
          state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        // Chain straight into the next frame so back-to-back bytes have no idle gap;
        // a cleared tx_en is honoured here, after the current frame completes.
        if (bit_end) begin
          if (tx_en && !fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_head;
            baud_d   = baud_div;
            state_d  = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Decoded from state so reset forces the line high without waiting for a clock
  always_comb begin
    uart_tx = 1'b1;
    case (state)
      TX_START:  uart_tx = 1'b0;
      TX_DATA:   uart_tx = shreg[bit_idx];
`ifdef BIRD_IO_PARITY_EN
      TX_PARITY: uart_tx = (^shreg) ^ odd_par;
`endif
      default:   uart_tx = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- read mux
  logic [ST_COUNT_W-1:0] count_ext;
  logic [15:0]           status;
  logic [15:0]           ctrl_rd;
  logic [15:0]           reg_rdata;

  assign count_ext = ST_COUNT_W'(fifo_count);

  always_comb begin
    status                                  = 16'd0;
    status[ST_FULL]                         = fifo_full;
    status[ST_EMPTY]                        = fifo_empty;
    status[ST_BUSY]                         = (state != TX_IDLE);
    status[ST_OVERFLOW]                     = overflow;
    status[ST_COUNT_LSB +: ST_COUNT_W]      = count_ext;

    ctrl_rd               = 16'd0;
    ctrl_rd[CTRL_TX_EN]   = tx_en;
    ctrl_rd[CTRL_ODD_PAR] = odd_par;

    reg_rdata = 16'd0;
    case (reg_off)
      REG_STATUS:  reg_rdata = status;
      REG_BAUDDIV: reg_rdata = baud_div;
      REG_CTRL:    reg_rdata = ctrl_rd;
      default:     reg_rdata = 16'd0;
    endcase

    cpu_rdata = io_sel ? reg_rdata : ram_rdata;
  end

endmodule

// File: tb/tb_bird_io_bridge.sv
// tb/tb_bird_io_bridge.sv - self-checking bench for bird_io_bridge

module tb_bird_io_bridge;

  localparam int          DEPTH  = 8;
  localparam logic [15:0] BRESET = 16'd433;
  localparam logic [11:0] A_TX   = 12'hFF0;
  localparam logic [11:0] A_ST   = 12'hFF1;
  localparam logic [11:0] A_BD   = 12'hFF2;
  localparam logic [11:0] A_CT   = 12'hFF3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] cpu_address = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_memwt = 1'b0;
  logic [15:0] cpu_rdata;
  logic [15:0] ram_rdata = '0;
  logic        ram_we;
  logic        uart_tx;

  int tests = 0;
  int fails = 0;

  logic [7:0] model_q[$];
  logic       exp_w[$];
  logic       fbits[$];
`ifdef BIRD_IO_PARITY_EN
  logic       model_odd = 1'b0;
`endif

  bird_io_bridge #(
    .FIFO_DEPTH (DEPTH),
    .BAUD_RESET (BRESET),
    .IO_BASE    (12'hFF0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_memwt   (cpu_memwt),
    .cpu_rdata   (cpu_rdata),
    .ram_rdata   (ram_rdata),
    .ram_we      (ram_we),
    .uart_tx     (uart_tx)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model helpers
  function automatic logic [15:0] status_of(input int cnt, input bit ovf, input bit busy);
    int v;
    v = cnt * 16 + (ovf ? 8 : 0) + (busy ? 4 : 0) + ((cnt == 0) ? 2 : 0) + ((cnt == DEPTH) ? 1 : 0);
    return v[15:0];
  endfunction

  // Line levels of one frame: start, 8 data bits LSB first, optional parity, stop
  function automatic void make_bits(input logic [7:0] b);
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < 8; i++) fbits.push_back(b[i]);
`ifdef BIRD_IO_PARITY_EN
    fbits.push_back((^b) ^ model_odd);
`endif
    fbits.push_back(1'b1);
  endfunction

  function automatic void push_frame(input logic [7:0] b, input int baud);
    make_bits(b);
    foreach (fbits[j])
      for (int c = 0; c <= baud; c++) exp_w.push_back(fbits[j]);
  endfunction

  // ---------------------------------------------------------------- bus helpers
  // Called at a negedge; returns at the following negedge with the write committed.
  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    cpu_address = a;
    cpu_wdata   = d;
    cpu_memwt   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_memwt   = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [15:0] d);
    cpu_memwt   = 1'b0;
    cpu_address = a;
    #1;
    d = cpu_rdata;
  endtask

  // Sample 0 is taken now, later samples on successive negedges
  task automatic check_wave(input string name);
    int   bad;
    logic got;
    bad = -1;
    got = 1'b0;
    for (int k = 0; k < exp_w.size(); k++) begin
      if (k > 0) @(negedge clk);
      if ((uart_tx !== exp_w[k]) && (bad < 0)) begin
        bad = k;
        got = uart_tx;
      end
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: sample %0d of %0d uart_tx=%b expected %b", name, bad, exp_w.size(), got, exp_w[bad]);
    end
    exp_w.delete();
  endtask

  task automatic check_idle(input string name);
    logic [15:0] d;
    @(negedge clk);
    rd(A_ST, d);
    tests++;
    if (uart_tx !== 1'b1 || d !== status_of(0, 0, 0)) begin
      fails++;
      $display("FAIL %s idle: uart_tx=%b status=%h expected 1 / %h", name, uart_tx, d, status_of(0, 0, 0));
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [15:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (uart_tx !== 1'b1 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: uart_tx=%b ram_we=%b expected 1 0", uart_tx, ram_we);
    end
    rst_n = 1'b1;
    @(negedge clk);
    rd(A_ST, d);
    tests++;
    if (d !== 16'h0002) begin fails++; $display("FAIL reset_status: got %h expected 0002", d); end
    rd(A_BD, d);
    tests++;
    if (d !== BRESET) begin fails++; $display("FAIL reset_bauddiv: got %h expected %h", d, BRESET); end
    rd(A_CT, d);
    tests++;
    if (d !== 16'h0001) begin fails++; $display("FAIL reset_ctrl: got %h expected 0001", d); end
  endtask

  task automatic test_ram_passthrough();
    logic [15:0] d;
    logic [11:0] a;
    int          bad;
    bad = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 12'h010 : 12'($urandom_range(0, 12'hFEF));
      ram_rdata   = 16'($urandom);
      cpu_address = a;
      cpu_wdata   = (i == 0) ? 16'h1234 : 16'($urandom);
      cpu_memwt   = 1'b1;
      #1;
      if (ram_we !== 1'b1 || cpu_rdata !== ram_rdata) bad++;
      @(posedge clk);
      @(negedge clk);
      cpu_memwt = 1'b0;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL ram_passthrough: %0d bad accesses, expected 0", bad); end
    rd(A_ST, d);
    tests++;
    if (d !== 16'h0002) begin fails++; $display("FAIL ram_no_fifo_effect: status %h expected 0002", d); end

    cpu_address = A_TX;
    cpu_memwt   = 1'b1;
    #1;
    tests++;
    if (ram_we !== 1'b0) begin fails++; $display("FAIL io_no_ram_we: ram_we=%b expected 0", ram_we); end
    cpu_memwt = 1'b0;

    @(negedge clk);
    wr(12'hFF5, 16'hFFFF);
    bad = 0;
    for (int off = 4; off < 16; off++) begin
      ram_rdata = 16'($urandom) | 16'h0001;
      rd(12'hFF0 + 12'(off), d);
      if (d !== 16'h0000) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL reserved_reads: %0d nonzero, expected 0", bad); end
    @(negedge clk);
  endtask

  task automatic test_regs();
    logic [15:0] d;
    logic [15:0] v;
    v = 16'($urandom);
    wr(A_BD, v);
    rd(A_BD, d);
    tests++;
    if (d !== v) begin fails++; $display("FAIL bauddiv_rw: got %h expected %h", d, v); end
    @(negedge clk);
    wr(A_CT, 16'hFFFF);
    rd(A_CT, d);
    tests++;
`ifdef BIRD_IO_PARITY_EN
    if (d !== 16'h0005) begin fails++; $display("FAIL ctrl_rw: got %h expected 0005", d); end
`else
    if (d !== 16'h0001) begin fails++; $display("FAIL ctrl_rw: got %h expected 0001", d); end
`endif
    @(negedge clk);
    wr(A_CT, 16'h0001);
  endtask

  task automatic test_single_frame();
    logic [15:0] d;
    wr(A_BD, 16'd3);
    wr(A_TX, 16'h00A5);
    rd(A_ST, d);
    tests++;
    if (uart_tx !== 1'b1 || d !== status_of(1, 0, 0)) begin
      fails++;
      $display("FAIL single_pre_pop: uart_tx=%b status=%h expected 1 / %h", uart_tx, d, status_of(1, 0, 0));
    end
    @(negedge clk);
    #1;
    tests++;
    if (cpu_rdata !== status_of(0, 0, 1)) begin
      fails++;
      $display("FAIL single_busy: status=%h expected %h", cpu_rdata, status_of(0, 0, 1));
    end
    push_frame(8'hA5, 3);
    check_wave("single_frame_a5");
    check_idle("single_frame");
  endtask

  task automatic test_random_frames();
    int          baud;
    logic [7:0]  b;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      baud = $urandom_range(0, 3);
      b    = 8'($urandom);
      wr(A_BD, 16'(baud));
      wr(A_TX, {8'($urandom), b});
      @(negedge clk);
      push_frame(b, baud);
      check_wave("random_frame");
      check_idle("random_frame");
    end
  endtask

  task automatic test_overflow_back_to_back();
    logic [15:0] d;
    bit          ovf;
    int          baud;
    ovf  = 0;
    baud = $urandom_range(0, 2);
    @(negedge clk);
    wr(A_CT, 16'h0000);
    wr(A_BD, 16'(baud));
    model_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else ovf = 1;
      wr(A_TX, {8'h00, b});
    end
    rd(A_ST, d);
    tests++;
    if (d !== status_of(model_q.size(), ovf, 0)) begin
      fails++;
      $display("FAIL overflow_status: got %h expected %h", d, status_of(model_q.size(), ovf, 0));
    end
    @(negedge clk);
    wr(A_CT, 16'h0003);
    rd(A_ST, d);
    tests++;
    if (d !== status_of(model_q.size(), 0, 0)) begin
      fails++;
      $display("FAIL overflow_clear: got %h expected %h", d, status_of(model_q.size(), 0, 0));
    end
    @(negedge clk);
    while (model_q.size() > 0) push_frame(model_q.pop_front(), baud);
    check_wave("back_to_back_frames");
    check_idle("back_to_back");
  endtask

  task automatic test_full_pop();
    logic [15:0] d;
    logic [7:0]  nb;
    int          baud;
    baud = $urandom_range(0, 1);
    @(negedge clk);
    wr(A_CT, 16'h0000);
    wr(A_BD, 16'(baud));
    model_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      model_q.push_back(b);
      wr(A_TX, {8'h00, b});
    end
    wr(A_CT, 16'h0001);
    nb = 8'($urandom);
    wr(A_TX, {8'h00, nb});
    push_frame(model_q.pop_front(), baud);
    model_q.push_back(nb);
    rd(A_ST, d);
    tests++;
    if (d !== status_of(DEPTH, 0, 1)) begin
      fails++;
      $display("FAIL full_push_pop: status %h expected %h", d, status_of(DEPTH, 0, 1));
    end
    while (model_q.size() > 0) push_frame(model_q.pop_front(), baud);
    check_wave("full_push_pop_frames");
    check_idle("full_push_pop");
  endtask

  task automatic test_baud_change();
    logic [15:0] d;
    logic [7:0]  b;
    int          bad;
    int          n;
    b = 8'($urandom);
    @(negedge clk);
    wr(A_BD, 16'd3);
    wr(A_TX, {8'h00, b});
    @(negedge clk);
    make_bits(b);
    foreach (fbits[j])
      for (int c = 0; c < ((j < 3) ? 4 : 2); c++) exp_w.push_back(fbits[j]);
    n   = exp_w.size();
    bad = -1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (uart_tx !== exp_w[k] && bad < 0) bad = k;
      if (k == 9) begin
        cpu_address = A_BD;
        cpu_wdata   = 16'd1;
        cpu_memwt   = 1'b1;
      end
      if (k == 10) begin
        rd(A_ST, d);
        tests++;
        if (d !== status_of(0, 0, 1)) begin
          fails++;
          $display("FAIL midframe_status: got %h expected %h", d, status_of(0, 0, 1));
        end
      end
      if (k == 11) begin
        rd(12'hFF5, d);
        tests++;
        if (d !== 16'h0000) begin fails++; $display("FAIL read_ff5: got %h expected 0000", d); end
      end
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL baud_change_wave: first wrong sample %0d expected %b", bad, exp_w[bad]);
    end
    exp_w.delete();
    check_idle("baud_change");
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    @(negedge clk);
    wr(A_BD, 16'd3);
    wr(A_TX, 16'h0000);
    wr(A_TX, 16'h00FF);
    repeat (12) @(negedge clk);
    tests++;
    if (uart_tx !== 1'b0) begin fails++; $display("FAIL in_data_bit: uart_tx=%b expected 0", uart_tx); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (uart_tx !== 1'b1) begin fails++; $display("FAIL async_reset_tx: uart_tx=%b expected 1", uart_tx); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(A_BD, d);
    tests++;
    if (d !== BRESET) begin fails++; $display("FAIL post_reset_bauddiv: got %h expected %h", d, BRESET); end
    rd(A_ST, d);
    tests++;
    if (d !== 16'h0002 || uart_tx !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_status: status=%h uart_tx=%b expected 0002 / 1", d, uart_tx);
    end
  endtask

  initial begin
    test_reset();
    test_ram_passthrough();
    test_regs();
    test_single_frame();
    test_random_frames();
    test_overflow_back_to_back();
    test_full_pop();
    test_baud_change();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
